// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the 16-bit restoring divider.
//   DATA_WIDTH : operand / result width (only 16 is supported)
//   CNT_WIDTH  : width of the quotient-bit counter (log2 of DATA_WIDTH)
//   state_e    : divider FSM states
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : div_pkg

// File: rtl/div_16bit_restoring.sv
// -----------------------------------------------------------------------------
// div_16bit_restoring
// Radix-2 restoring divider, one quotient bit per clock, MSB first. Signed
// operation divides magnitudes and fixes the signs on the last iteration.
// Division by zero bypasses the iteration and reports o_err.
//
// Ports
//   i_clk    : clock, all state changes on the rising edge
//   i_rst    : synchronous active-high reset
//   i_start  : request, accepted only in IDLE
//   i_sign   : 1 = two's-complement operands, 0 = unsigned
//   i_num_x  : dividend
//   i_num_y  : divisor
//   o_busy   : high whenever the FSM is not in IDLE
//   o_end    : one-cycle done pulse, results valid in that cycle
//   o_quo    : quotient, held until the next accepted request
//   o_rem    : remainder, held until the next accepted request
//   o_err    : divide-by-zero flag, updated together with o_quo
// -----------------------------------------------------------------------------
module div_16bit_restoring #(
    parameter int DATA_WIDTH = div_pkg::DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sign,
    input  logic [DATA_WIDTH-1:0] i_num_x,
    input  logic [DATA_WIDTH-1:0] i_num_y,
    output logic                  o_busy,
    output logic                  o_end,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic                  o_err
);

    import div_pkg::state_e;
    import div_pkg::IDLE;
    import div_pkg::CALC;
    import div_pkg::DONE;
    import div_pkg::CNT_WIDTH;

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

    state_e               state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [W:0]           prem_q,    prem_d;    // partial remainder, 1 guard bit
    logic [W-1:0]         dvd_q,     dvd_d;     // dividend shifts out, quotient shifts in
    logic [W-1:0]         dvs_q,     dvs_d;     // divisor magnitude
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [W-1:0]         quo_q,     quo_d;
    logic [W-1:0]         rem_q,     rem_d;
    logic                 err_q,     err_d;
    logic                 busy_q,    busy_d;
    logic                 end_q,     end_d;

    // Datapath for one iteration
    logic [W-1:0] x_mag, y_mag;
    logic [W:0]   shifted, trial, prem_next;
    logic         q_bit;
    logic [W-1:0] dvd_next, quo_fin, rem_fin;

    always_comb begin
        // Magnitudes of the request operands; 0x8000 maps to itself, which
        // is the correct unsigned magnitude.
        x_mag = (i_sign && i_num_x[W-1]) ? -i_num_x : i_num_x;
        y_mag = (i_sign && i_num_y[W-1]) ? -i_num_y : i_num_y;

        // prem_q < dvs_q always holds, so the trial difference fits in W+1
        // bits and its top bit is a reliable borrow.
        shifted   = {prem_q[W-1:0], dvd_q[W-1]};
        trial     = shifted - {1'b0, dvs_q};
        q_bit     = ~trial[W];
        prem_next = q_bit ? trial : shifted;
        dvd_next  = {dvd_q[W-2:0], q_bit};

        quo_fin = quo_neg_q ? -dvd_next          : dvd_next;
        rem_fin = rem_neg_q ? -prem_next[W-1:0]  : prem_next[W-1:0];
    end

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_num_y == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = i_num_x;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = CALC;
                        dvd_d     = x_mag;
                        dvs_d     = y_mag;
                        quo_neg_d = i_sign & (i_num_x[W-1] ^ i_num_y[W-1]);
                        rem_neg_d = i_sign & i_num_x[W-1];
                        prem_d    = '0;
                        cnt_d     = '0;
                    end
                end
            end
            CALC: begin
                prem_d = prem_next;
                dvd_d  = dvd_next;
                cnt_d  = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    quo_d   = quo_fin;
                    rem_d   = rem_fin;
                    err_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with state_q.
        busy_d = (state_d != IDLE);
        end_d  = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale results visible.
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
        end
    end

    assign o_busy = busy_q;
    assign o_end  = end_q;
    assign o_quo  = quo_q;
    assign o_rem  = rem_q;
    assign o_err  = err_q;

endmodule : div_16bit_restoring
